audio_playback_engine: RTL and testbench
========================================

Name: audio_playback_engine

Overview:
Playback side of the audio enable/select/complete handshake. The sound-effect controller drives en and a 2-bit clip select. This block latches the clip, streams 8-bit unsigned PCM samples from a synchronous sample ROM at a fixed sample rate, and renders them as PWM on the speaker pin. It pulses playback_complete when the clip ends.

Parameters:
TICK_DIV, 6250, clk cycles per sample (50 MHz / 8 kHz); legal range is 3 or more.
ADDR_W, 16, sample ROM address width.
SAMPLE_W, 8, PCM sample width; also the PWM counter width.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
en  in  1  playback request level from the controller
audio_select  in  2  clip select; 00 = none, 01..11 = clip 1..3
rom_rd  out  1  sample ROM read strobe
rom_addr  out  ADDR_W  sample ROM address
rom_data  in  SAMPLE_W  ROM data, valid the cycle after rom_rd
pwm_out  out  1  PWM audio output
busy  out  1  high while a clip is active
playback_complete  out  1  one-cycle pulse at natural clip end

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; outputs rom_rd=0, rom_addr=0, pwm_out=0, busy=0, playback_complete=0; sample=0, tick_cnt=0, pwm_cnt=0, armed=1.
- armed: cleared when a clip starts; set again in any cycle where en=0. A start requires armed=1. A held-high en therefore never retriggers after completion.
- IDLE: start when en=1, armed=1 and audio_select!=00.
  - Latch sel.
  - remaining = CLIP_LEN[sel].
  - If CLIP_LEN=0: go to DONE next cycle.
  - Otherwise: rom_rd=1, rom_addr=CLIP_BASE[sel], go to PRIME.
  - en=1 with select 00 does nothing.
- PRIME (1 cycle):
  - sample <= rom_data; tick_cnt <= 0; remaining <= remaining-1; busy=1; go to PLAY.
  - Start to first sample in the register is 2 cycles.
- PLAY: tick_cnt increments every cycle and wraps at TICK_DIV-1.
  - At tick_cnt==TICK_DIV-2 with remaining!=0: rom_rd=1, rom_addr<=rom_addr+1.
  - At tick_cnt==TICK_DIV-1: if remaining!=0, sample<=rom_data and remaining decrements. If remaining==0, go to DONE.
  - Every sample is held exactly TICK_DIV cycles.
- DONE (1 cycle): playback_complete=1, busy=0, sample<=0, then go to IDLE.
- Abort: en=0 in PRIME or PLAY forces IDLE next cycle. On abort: busy=0, sample=0, no complete pulse.
- audio_select changes during playback are ignored; the selection is latched.
- rom_rd is a single-cycle strobe. rom_addr holds its value between strobes.
- PWM:
  - pwm_cnt is a free-running SAMPLE_W counter.
  - pwm_out = busy & (pwm_cnt < sample), registered with 1-cycle latency.
  - sample 0 gives constant low; 0xFF gives 255/256 duty.
- Address arithmetic is modulo 2^ADDR_W. A clip may wrap across the top of the ROM.
- A start request in the same cycle as DONE is ignored: armed=0 and state is not IDLE.

Decomposition:
- Package audio_pkg:
  - clip_id_t (2-bit enum: CLIP_NONE, CLIP_1..CLIP_3)
  - CLIP_BASE[1:3] and CLIP_LEN[1:3] constant arrays
  - playback state enum (IDLE, PRIME, PLAY, DONE)
- One sub-module, pwm_modulator: pwm_cnt, comparator and output register, parameterised by SAMPLE_W. The FSM, tick counter and ROM addressing live in the top.

Test Plan:
All scenarios use TICK_DIV=4, CLIP_BASE={0x10,0x40,0x80}, CLIP_LEN={3,1,0}, and a ROM model returning data = address.
1. en=1, select=01 → rom_rd at cycles 0, 4, 8 with addresses 0x10, 0x11, 0x12. sample holds 0x10/0x11/0x12 for 4 cycles each. A single playback_complete pulse follows the 12th PLAY cycle; busy falls with it.
2. Keep en=1 after scenario 1 completes → no restart. Drop en for 1 cycle, raise it again → playback restarts at 0x10.
3. select=11 (length 0) → no rom_rd; playback_complete pulses 1 cycle after start; busy never rises.
4. en drops at the 2nd sample of clip 1 → IDLE next cycle, pwm_out=0, no complete pulse. Switching select to 10 mid-clip before that point → addresses stay 0x10–0x12.
5. Force sample=0x00 and sample=0xFF in PLAY over 256 cycles → pwm_out high count is 0 and 255 respectively.
6. Assert reset_n=0 mid-PLAY (asynchronous, off clock edge) → all outputs 0 immediately. After release, en=1 with select=10 → address 0x40 played, then complete.

Source files
------------

// File: rtl/audio_playback_engine_pkg.sv
`default_nettype none
//==== audio_pkg : clip table and playback state types (rev 1.0) ====
package audio_pkg;

  typedef enum logic [1:0] {
    CLIP_NONE = 2'd0,
    CLIP_1    = 2'd1,
    CLIP_2    = 2'd2,
    CLIP_3    = 2'd3
  } clip_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2,
    DONE  = 2'd3
  } play_state_t;

  // Entry 0 is the "no clip" slot so the tables index directly by clip_id_t.
  localparam logic [15:0] CLIP_BASE [4] = '{16'h0000, 16'h0010, 16'h0040, 16'h0080};
  localparam logic [15:0] CLIP_LEN  [4] = '{16'd0,    16'd3,    16'd1,    16'd0};

endpackage
`default_nettype wire

// File: rtl/audio_playback_engine_pwm.sv
`default_nettype none
//==== pwm_modulator : free-running PWM compare with registered output (rev 1.0) ====
module pwm_modulator #(
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                pwm_out
);

  logic [SAMPLE_W-1:0] pwm_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + SAMPLE_W'(1);
      pwm_out <= enable && (pwm_cnt < sample);
    end
  end

endmodule
`default_nettype wire

// File: rtl/audio_playback_engine.sv
`default_nettype none
//==== audio_playback_engine : clip FSM, sample-rate ticker and ROM streaming (rev 1.0) ====
module audio_playback_engine
  import audio_pkg::*;
#(
  parameter int TICK_DIV = 6250,
  parameter int ADDR_W   = 16,
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic [1:0]          audio_select,
  output logic                rom_rd,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_data,
  output logic                pwm_out,
  output logic                busy,
  output logic                playback_complete
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_FETCH = TICK_W'(TICK_DIV - 2);

  play_state_t         state;
  clip_id_t            req;
  logic                armed;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   remaining;
  logic [TICK_W-1:0]   tick_cnt;
  logic [SAMPLE_W-1:0] sample;
  logic                start;
  logic                fetch;
  logic [ADDR_W-1:0]   fetch_addr;

  assign req   = clip_id_t'(audio_select);
  assign start = (state == IDLE) && en && armed && (req != CLIP_NONE);

  // The strobe is issued in the cycle the FSM decides to fetch, so the ROM
  // answers exactly when PRIME / the last tick of a sample consumes rom_data.
  assign fetch = reset_n &&
                 ((start && (CLIP_LEN[req] != 16'd0)) ||
                  ((state == PLAY) && en && (tick_cnt == TICK_FETCH) && (remaining != '0)));
  assign fetch_addr = (state == IDLE) ? ADDR_W'(CLIP_BASE[req]) : addr_q + ADDR_W'(1);
  assign rom_rd     = fetch;
  assign rom_addr   = fetch ? fetch_addr : addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      armed             <= 1'b1;
      addr_q            <= '0;
      remaining         <= '0;
      tick_cnt          <= '0;
      sample            <= '0;
      busy              <= 1'b0;
      playback_complete <= 1'b0;
    end else begin
      playback_complete <= 1'b0;
      if (!en) armed <= 1'b1;
      if (fetch) addr_q <= fetch_addr;
      case (state)
        IDLE: begin
          if (start) begin
            armed     <= 1'b0;
            remaining <= ADDR_W'(CLIP_LEN[req]);
            if (CLIP_LEN[req] == 16'd0) begin
              state             <= DONE;
              playback_complete <= 1'b1;
            end else begin
              state <= PRIME;
              busy  <= 1'b1;
            end
          end
        end
        PRIME: begin
          if (!en) begin
            state  <= IDLE;
            busy   <= 1'b0;
            sample <= '0;
          end else begin
            sample    <= rom_data;
            tick_cnt  <= '0;
            remaining <= remaining - ADDR_W'(1);
            state     <= PLAY;
          end
        end
        PLAY: begin
          if (!en) begin
            state  <= IDLE;
            busy   <= 1'b0;
            sample <= '0;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (remaining != '0) begin
              sample    <= rom_data;
              remaining <= remaining - ADDR_W'(1);
            end else begin
              state             <= DONE;
              busy              <= 1'b0;
              sample            <= '0;
              playback_complete <= 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  pwm_modulator #(
    .SAMPLE_W (SAMPLE_W)
  ) u_pwm (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (busy),
    .sample  (sample),
    .pwm_out (pwm_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_audio_playback_engine.sv
`default_nettype none
//==== tb_audio_playback_engine : directed bench for the playback engine (rev 1.0) ====
module tb_audio_playback_engine;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [1:0]  audio_select;
  logic        rom_rd;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        pwm_out;
  logic        busy;
  logic        playback_complete;

  logic        tp_en;
  logic [7:0]  tp_sample;
  logic        tp_pwm;

  int n_assert = 0;
  int n_fail   = 0;
  int hi;
  int completes;

  always #5 clk = ~clk;

  audio_playback_engine #(
    .TICK_DIV (4),
    .ADDR_W   (16),
    .SAMPLE_W (8)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .en                (en),
    .audio_select      (audio_select),
    .rom_rd            (rom_rd),
    .rom_addr          (rom_addr),
    .rom_data          (rom_data),
    .pwm_out           (pwm_out),
    .busy              (busy),
    .playback_complete (playback_complete)
  );

  // Standalone modulator so duty cycles can be measured with a held sample.
  pwm_modulator #(
    .SAMPLE_W (8)
  ) u_pwm_ref (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (tp_en),
    .sample  (tp_sample),
    .pwm_out (tp_pwm)
  );

  // Synchronous ROM whose contents equal the low address byte.
  always_ff @(posedge clk) begin
    if (rom_rd) rom_data <= rom_addr[7:0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    en           = 1'b0;
    audio_select = 2'b00;
    tp_en        = 1'b0;
    tp_sample    = 8'h00;
    #3;
    chk("rst_rd",   32'(rom_rd), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_pwm",  32'(pwm_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(playback_complete), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Select 00 with en high must not start anything.
    en = 1'b1;
    #1;
    chk("sel0_rd", 32'(rom_rd), 32'd0);
    tick();
    chk("sel0_busy", 32'(busy), 32'd0);
    en = 1'b0;
    tick();

    // Scenario 1: clip 1, three samples at 0x10..0x12.
    audio_select = 2'b01;
    en = 1'b1;
    #1;
    chk("s1_rd_c0",   32'(rom_rd), 32'd1);
    chk("s1_addr_c0", 32'(rom_addr), 32'h10);
    tick();
    chk("s1_prime_busy", 32'(busy), 32'd1);
    chk("s1_prime_rd",   32'(rom_rd), 32'd0);
    for (int c = 2; c <= 13; c++) begin
      tick();
      chk("s1_sample", 32'(dut.sample), 32'(16 + (c - 2) / 4));
      chk("s1_rd",     32'(rom_rd), (c == 4 || c == 8) ? 32'd1 : 32'd0);
      chk("s1_addr",   32'(rom_addr), (c < 4) ? 32'h10 : (c < 8) ? 32'h11 : 32'h12);
      chk("s1_busy",   32'(busy), 32'd1);
      chk("s1_nodone", 32'(playback_complete), 32'd0);
    end
    tick();
    chk("s1_done",      32'(playback_complete), 32'd1);
    chk("s1_busy_fall", 32'(busy), 32'd0);
    tick();
    chk("s1_done_pulse", 32'(playback_complete), 32'd0);

    // Scenario 2: held en does not retrigger; a low cycle re-arms.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s2_norestart_rd",   32'(rom_rd), 32'd0);
      chk("s2_norestart_busy", 32'(busy), 32'd0);
    end
    en = 1'b0;
    tick();
    en = 1'b1;
    #1;
    chk("s2_restart_rd",   32'(rom_rd), 32'd1);
    chk("s2_restart_addr", 32'(rom_addr), 32'h10);
    completes = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      completes += int'(playback_complete);
    end
    chk("s2_one_complete", 32'(completes), 32'd1);
    en = 1'b0;
    tick();

    // Scenario 3: zero-length clip.
    audio_select = 2'b11;
    en = 1'b1;
    #1;
    chk("s3_no_rd", 32'(rom_rd), 32'd0);
    tick();
    chk("s3_done",    32'(playback_complete), 32'd1);
    chk("s3_no_busy", 32'(busy), 32'd0);
    tick();
    chk("s3_pulse_end", 32'(playback_complete), 32'd0);
    chk("s3_no_busy2",  32'(busy), 32'd0);
    en = 1'b0;
    tick();

    // Scenario 4: select change ignored, then abort on the second sample.
    audio_select = 2'b01;
    en = 1'b1;
    tick();
    audio_select = 2'b10;
    for (int c = 2; c <= 6; c++) begin
      tick();
      chk("s4_addr", 32'(rom_addr), (c < 4) ? 32'h10 : 32'h11);
    end
    chk("s4_sample2", 32'(dut.sample), 32'h11);
    en = 1'b0;
    tick();
    chk("s4_idle",    32'(dut.state), 32'(IDLE));
    chk("s4_busy",    32'(busy), 32'd0);
    chk("s4_nodone",  32'(playback_complete), 32'd0);
    chk("s4_sample0", 32'(dut.sample), 32'd0);
    completes = 0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      completes += int'(playback_complete);
      hi += int'(pwm_out);
    end
    chk("s4_pwm_low",   32'(hi), 32'd0);
    chk("s4_no_pulse",  32'(completes), 32'd0);

    // Scenario 5: duty cycle over one full PWM period.
    tp_en = 1'b1;
    tp_sample = 8'h00;
    tick();
    hi = 0;
    for (int i = 0; i < 256; i++) begin tick(); hi += int'(tp_pwm); end
    chk("s5_duty_00", 32'(hi), 32'd0);
    tp_sample = 8'hFF;
    tick();
    hi = 0;
    for (int i = 0; i < 256; i++) begin tick(); hi += int'(tp_pwm); end
    chk("s5_duty_ff", 32'(hi), 32'd255);
    tp_sample = 8'h80;
    tick();
    hi = 0;
    for (int i = 0; i < 256; i++) begin tick(); hi += int'(tp_pwm); end
    chk("s5_duty_80", 32'(hi), 32'd128);
    tp_en = 1'b0;
    tick();
    hi = 0;
    for (int i = 0; i < 256; i++) begin tick(); hi += int'(tp_pwm); end
    chk("s5_duty_off", 32'(hi), 32'd0);

    // Scenario 6: asynchronous reset mid-PLAY, then clip 2.
    audio_select = 2'b01;
    en = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    chk("s6_pre_busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s6_rst_rd",   32'(rom_rd), 32'd0);
    chk("s6_rst_addr", 32'(rom_addr), 32'd0);
    chk("s6_rst_pwm",  32'(pwm_out), 32'd0);
    chk("s6_rst_busy", 32'(busy), 32'd0);
    chk("s6_rst_done", 32'(playback_complete), 32'd0);
    audio_select = 2'b10;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("s6_rd",   32'(rom_rd), 32'd1);
    chk("s6_addr", 32'(rom_addr), 32'h40);
    tick();
    chk("s6_prime_busy", 32'(busy), 32'd1);
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk("s6_sample", 32'(dut.sample), 32'h40);
      chk("s6_no_rd",  32'(rom_rd), 32'd0);
    end
    tick();
    chk("s6_done", 32'(playback_complete), 32'd1);
    chk("s6_busy", 32'(busy), 32'd0);
    en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
